// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: multi-push, multi-pop circular queue.
// Define INST_QUEUE_BYPASS_EN to present pushes to decode in the same cycle when the queue is empty.
module inst_queue #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 16,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           stall,
  input  logic                           push_valid,
  input  logic [$clog2(FETCH_N+1)-1:0]   push_num,
  input  logic [PC_W-1:0]                push_pc,
  input  logic [FETCH_N*DATA_W-1:0]      push_inst,
  output logic [ISSUE_N-1:0]             out_valid,
  output logic [ISSUE_N*DATA_W-1:0]      out_inst,
  output logic [ISSUE_N*PC_W-1:0]        out_pc,
  input  logic [$clog2(ISSUE_N+1)-1:0]   pop_num,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           stallreq_for_fifo
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(FETCH_N + 1);

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_r;

  logic          push_legal;
  logic          push_ok;
  logic [CW-1:0] pushed;
  logic [CW-1:0] avail;
  logic [CW-1:0] popped;

  assign count             = count_r;
  assign stallreq_for_fifo = count_r > CW'(DEPTH - FETCH_N);

  assign push_legal = (push_num != '0) && (push_num <= NW'(FETCH_N));
  assign push_ok    = push_valid && push_legal && !stallreq_for_fifo && !flush;
  assign pushed     = push_ok ? CW'(push_num) : '0;

`ifdef INST_QUEUE_BYPASS_EN
  // An empty queue lets decode consume the slots being pushed this cycle.
  assign avail = (count_r == '0) ? pushed : count_r;
`else
  assign avail = count_r;
`endif

  always_comb begin
    popped = CW'(pop_num);
    if (popped > CW'(ISSUE_N)) popped = CW'(ISSUE_N);
    if (popped > avail)        popped = avail;
    if (stall || flush)        popped = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(popped);
      wr_ptr  <= wr_ptr + PW'(pushed);
      count_r <= count_r + pushed - popped;
    end
  end

  // Each entry keeps its own PC so the order survives pointer wrap without recomputation.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < FETCH_N; i++) begin
        if (i < int'(push_num)) begin
          inst_mem[wr_ptr + PW'(i)] <= push_inst[i*DATA_W +: DATA_W];
          pc_mem[wr_ptr + PW'(i)]   <= push_pc + PC_W'(4 * i);
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int j = 0; j < ISSUE_N; j++) begin
      if (j < int'(count_r)) begin
        out_valid[j]                = 1'b1;
        out_inst[j*DATA_W +: DATA_W] = inst_mem[rd_ptr + PW'(j)];
        out_pc[j*PC_W +: PC_W]       = pc_mem[rd_ptr + PW'(j)];
      end
`ifdef INST_QUEUE_BYPASS_EN
      else if ((count_r == '0) && push_ok && (j < int'(push_num)) && (j < FETCH_N)) begin
        out_valid[j]                = 1'b1;
        out_inst[j*DATA_W +: DATA_W] = push_inst[j*DATA_W +: DATA_W];
        out_pc[j*PC_W +: PC_W]       = push_pc + PC_W'(4 * j);
      end
`endif
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with DEPTH=8, FETCH_N=2, ISSUE_N=2 (default build).
module tb_inst_queue;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int DEPTH   = 8;
  localparam int FETCH_N = 2;
  localparam int ISSUE_N = 2;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      stall;
  logic                      push_valid;
  logic [1:0]                push_num;
  logic [PC_W-1:0]           push_pc;
  logic [FETCH_N*DATA_W-1:0] push_inst;
  logic [ISSUE_N-1:0]        out_valid;
  logic [ISSUE_N*DATA_W-1:0] out_inst;
  logic [ISSUE_N*PC_W-1:0]   out_pc;
  logic [1:0]                pop_num;
  logic [3:0]                count;
  logic                      stallreq_for_fifo;

  int total;
  int passed;

  inst_queue #(
    .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .FETCH_N(FETCH_N), .ISSUE_N(ISSUE_N)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .push_valid(push_valid), .push_num(push_num), .push_pc(push_pc), .push_inst(push_inst),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .pop_num(pop_num), .count(count), .stallreq_for_fifo(stallreq_for_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [1:0] n, input logic [31:0] pc,
                            input logic [31:0] i0, input logic [31:0] i1);
    push_valid = v;
    push_num   = n;
    push_pc    = pc;
    push_inst  = {i1, i0};
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; stall = 1'b0; pop_num = 2'd0;
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    step(); step();
    total++; if (count !== 4'd0) $display("FAIL reset_count got %0d expected 0", count); else passed++;
    total++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid got %b expected 00", out_valid); else passed++;
    total++; if (stallreq_for_fifo !== 1'b0) $display("FAIL reset_stallreq got %b expected 0", stallreq_for_fifo); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_push_basic();
    drive_push(1'b1, 2'd2, 32'hBFC00000, 32'h11111111, 32'h22222222);
    step();
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (count !== 4'd2) $display("FAIL basic_count got %0d expected 2", count); else passed++;
    total++; if (out_valid !== 2'b11) $display("FAIL basic_out_valid got %b expected 11", out_valid); else passed++;
    total++; if (out_pc[31:0] !== 32'hBFC00000) $display("FAIL basic_pc0 got %h expected bfc00000", out_pc[31:0]); else passed++;
    total++; if (out_pc[63:32] !== 32'hBFC00004) $display("FAIL basic_pc1 got %h expected bfc00004", out_pc[63:32]); else passed++;
    total++; if (out_inst[31:0] !== 32'h11111111) $display("FAIL basic_inst0 got %h expected 11111111", out_inst[31:0]); else passed++;
    total++; if (out_inst[63:32] !== 32'h22222222) $display("FAIL basic_inst1 got %h expected 22222222", out_inst[63:32]); else passed++;
    pop_num = 2'd2;
    step();
    pop_num = 2'd0;
    total++; if (count !== 4'd0) $display("FAIL basic_drain_count got %0d expected 0", count); else passed++;
    total++; if (out_valid !== 2'b00) $display("FAIL basic_drain_valid got %b expected 00", out_valid); else passed++;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive_push(1'b1, 2'd2, 32'h1000 + 32'(8*k), 32'hC0000000 + 32'(2*k), 32'hC0000001 + 32'(2*k));
      step();
      total++; if (count !== 4'(2*(k+1))) $display("FAIL fill_count[%0d] got %0d expected %0d", k, count, 2*(k+1)); else passed++;
      total++; if (stallreq_for_fifo !== (k == 3)) $display("FAIL fill_stallreq[%0d] got %b expected %b", k, stallreq_for_fifo, (k == 3)); else passed++;
    end
    drive_push(1'b1, 2'd2, 32'h9000, 32'hDEADBEEF, 32'hDEADBEEF);
    step();
    total++; if (count !== 4'd8) $display("FAIL full_push_count got %0d expected 8", count); else passed++;
    total++; if (out_pc[31:0] !== 32'h1000) $display("FAIL full_push_pc0 got %h expected 00001000", out_pc[31:0]); else passed++;
    total++; if (out_inst[31:0] !== 32'hC0000000) $display("FAIL full_push_inst0 got %h expected c0000000", out_inst[31:0]); else passed++;
    // A pop in the same cycle must not make room for the push.
    pop_num = 2'd2;
    step();
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (count !== 4'd6) $display("FAIL full_pushpop_count got %0d expected 6", count); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_pc[31:0] !== 32'h1008 + 32'(8*k)) $display("FAIL drain_pc0[%0d] got %h expected %h", k, out_pc[31:0], 32'h1008 + 32'(8*k)); else passed++;
      total++; if (out_pc[63:32] !== 32'h100C + 32'(8*k)) $display("FAIL drain_pc1[%0d] got %h expected %h", k, out_pc[63:32], 32'h100C + 32'(8*k)); else passed++;
      total++; if (out_inst[63:32] !== 32'hC0000003 + 32'(2*k)) $display("FAIL drain_inst1[%0d] got %h expected %h", k, out_inst[63:32], 32'hC0000003 + 32'(2*k)); else passed++;
      step();
    end
    pop_num = 2'd0;
    total++; if (count !== 4'd0) $display("FAIL fill_final_count got %0d expected 0", count); else passed++;
  endtask

  task automatic test_wrap();
    pop_num = 2'd2;
    for (int k = 0; k < 20; k++) begin
      drive_push(1'b1, 2'd1, 32'h3000 + 32'(4*k), 32'hA0000000 + 32'(k), 32'h0);
      step();
      total++; if (count !== 4'd1) $display("FAIL wrap_count[%0d] got %0d expected 1", k, count); else passed++;
      total++; if (out_valid !== 2'b01) $display("FAIL wrap_valid[%0d] got %b expected 01", k, out_valid); else passed++;
      total++; if (out_pc[31:0] !== 32'h3000 + 32'(4*k)) $display("FAIL wrap_pc[%0d] got %h expected %h", k, out_pc[31:0], 32'h3000 + 32'(4*k)); else passed++;
      total++; if (out_inst[31:0] !== 32'hA0000000 + 32'(k)) $display("FAIL wrap_inst[%0d] got %h expected %h", k, out_inst[31:0], 32'hA0000000 + 32'(k)); else passed++;
    end
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    pop_num = 2'd0;
    total++; if (count !== 4'd0) $display("FAIL wrap_final_count got %0d expected 0", count); else passed++;
  endtask

  task automatic test_flush();
    drive_push(1'b1, 2'd2, 32'h4000, 32'h1, 32'h2); step();
    drive_push(1'b1, 2'd2, 32'h4008, 32'h3, 32'h4); step();
    drive_push(1'b1, 2'd1, 32'h4010, 32'h5, 32'h0); step();
    total++; if (count !== 4'd5) $display("FAIL flush_setup_count got %0d expected 5", count); else passed++;
    drive_push(1'b1, 2'd2, 32'h4014, 32'h6, 32'h7);
    pop_num = 2'd2;
    flush   = 1'b1;
    step();
    flush   = 1'b0;
    pop_num = 2'd0;
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (count !== 4'd0) $display("FAIL flush_count got %0d expected 0", count); else passed++;
    total++; if (out_valid !== 2'b00) $display("FAIL flush_valid got %b expected 00", out_valid); else passed++;
    total++; if (dut.rd_ptr !== 3'd0) $display("FAIL flush_rd_ptr got %0d expected 0", dut.rd_ptr); else passed++;
    total++; if (dut.wr_ptr !== 3'd0) $display("FAIL flush_wr_ptr got %0d expected 0", dut.wr_ptr); else passed++;
    drive_push(1'b1, 2'd1, 32'h5000, 32'h55555555, 32'h0);
    step();
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (out_pc[31:0] !== 32'h5000) $display("FAIL post_flush_pc got %h expected 00005000", out_pc[31:0]); else passed++;
    total++; if (out_valid !== 2'b01) $display("FAIL post_flush_valid got %b expected 01", out_valid); else passed++;
    pop_num = 2'd1;
    step();
    pop_num = 2'd0;
  endtask

  task automatic test_stall();
    drive_push(1'b1, 2'd2, 32'h2000, 32'h10, 32'h11); step();
    drive_push(1'b1, 2'd2, 32'h2008, 32'h12, 32'h13); step();
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (count !== 4'd4) $display("FAIL stall_setup_count got %0d expected 4", count); else passed++;
    stall   = 1'b1;
    pop_num = 2'd2;
    step();
    total++; if (count !== 4'd4) $display("FAIL stall_count got %0d expected 4", count); else passed++;
    total++; if (out_pc[31:0] !== 32'h2000) $display("FAIL stall_pc0 got %h expected 00002000", out_pc[31:0]); else passed++;
    stall = 1'b0;
    step();
    total++; if (count !== 4'd2) $display("FAIL unstall_count got %0d expected 2", count); else passed++;
    total++; if (out_pc[31:0] !== 32'h2008) $display("FAIL unstall_pc0 got %h expected 00002008", out_pc[31:0]); else passed++;
    total++; if (out_inst[63:32] !== 32'h13) $display("FAIL unstall_inst1 got %h expected 00000013", out_inst[63:32]); else passed++;
    step();
    pop_num = 2'd0;
    total++; if (count !== 4'd0) $display("FAIL stall_final_count got %0d expected 0", count); else passed++;
  endtask

  task automatic test_illegal();
    drive_push(1'b1, 2'd0, 32'h6000, 32'h1, 32'h2);
    step();
    total++; if (count !== 4'd0) $display("FAIL illegal_num0_count got %0d expected 0", count); else passed++;
    drive_push(1'b1, 2'd3, 32'h6000, 32'h1, 32'h2);
    step();
    total++; if (count !== 4'd0) $display("FAIL illegal_num3_count got %0d expected 0", count); else passed++;
    drive_push(1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    pop_num = 2'd2;
    step();
    pop_num = 2'd0;
    total++; if (count !== 4'd0) $display("FAIL empty_pop_count got %0d expected 0", count); else passed++;
    total++; if (out_valid !== 2'b00) $display("FAIL empty_pop_valid got %b expected 00", out_valid); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_push_basic();
    test_fill();
    test_wrap();
    test_flush();
    test_stall();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised instruction buffer between IF and ID in the multi-issue core.
- Accepts up to FETCH_N instructions per cycle from the fetch stage, each tagged with its PC.
- Presents up to ISSUE_N oldest instructions to decode, in program order.
- Drives stallreq_for_fifo to the stall controller when it cannot accept a full fetch group.

Parameters:
DATA_W, 32, instruction width in bits
PC_W, 32, PC width in bits
DEPTH, 16, entry count; power of two, >= 2*FETCH_N
FETCH_N, 2, max instructions pushed per cycle
ISSUE_N, 2, max instructions presented/popped per cycle; <= DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
flush  in  1  discard all contents (exception/redirect)
stall  in  1  decode stalled; pops ignored
push_valid  in  1  fetch group present
push_num  in  $clog2(FETCH_N+1)  valid slots in group, 1..FETCH_N, slot 0 first
push_pc  in  PC_W  PC of slot 0; slot i PC = push_pc + 4*i
push_inst  in  FETCH_N*DATA_W  slot i at bits [i*DATA_W +: DATA_W]
out_valid  out  ISSUE_N  bit j set if entry j (0 = oldest) valid
out_inst  out  ISSUE_N*DATA_W  entry j instruction
out_pc  out  ISSUE_N*PC_W  entry j PC
pop_num  in  $clog2(ISSUE_N+1)  entries consumed this cycle
count  out  $clog2(DEPTH)+1  current occupancy
stallreq_for_fifo  out  1  free slots < FETCH_N

Behaviour:
- State: rd_ptr and wr_ptr, $clog2(DEPTH) bits each, wrap modulo DEPTH; count register, $clog2(DEPTH)+1 bits; storage array is not reset.
- Reset (rst=0, async): rd_ptr=0, wr_ptr=0, count=0. Therefore out_valid=0 and stallreq_for_fifo=0.
- free = DEPTH - count. stallreq_for_fifo = (free < FETCH_N), combinational from the registered count.
- Push accepted iff push_valid && !stallreq_for_fifo && !flush. Pushed = push_num.
  - Slot i writes mem[wr_ptr+i].
  - wr_ptr advances by push_num.
  - Free space is checked on the pre-cycle count; a same-cycle pop does not create room.
- push_num=0 or push_num>FETCH_N with push_valid=1 is illegal; the design ignores it (no write).
- out_valid[j] = (j < count). out_inst/out_pc[j] = mem[rd_ptr+j] when valid, else zero.
- Latency push->out is 1 cycle; there is no bypass (see optional feature).
- Pop: effective pop = stall ? 0 : min(pop_num, count). rd_ptr advances by the effective pop.
- count_next = count + pushed - popped. Simultaneous push and pop is legal.
- flush has priority over push and pop. Next state: rd_ptr=wr_ptr=0, count=0. The cycle's push is dropped.
- Full: count=DEPTH. stallreq_for_fifo=1; the fetch stage is frozen by the stall controller, and any push is ignored.
- Empty: out_valid=0; pop_num is ignored.
- Order is preserved across pointer wrap. PC of each entry is stored per entry, never recomputed.

Optional Feature:
- INST_QUEUE_BYPASS_EN defined:
  - When count=0 and a push is accepted, out_* present the pushed slots in the same cycle.
  - Bypassed fields: out_valid[j] for j<min(push_num,ISSUE_N), out_inst from push_inst, out_pc = push_pc+4*j.
  - pop_num in that cycle may consume bypassed entries. The entries are still written, and rd_ptr advances by the pop, giving zero-latency issue.
- Not defined: strict 1-cycle push->out latency; no combinational path from push_* to out_*.

Test Plan:
- DEPTH=8, FETCH_N=2, ISSUE_N=2. Reset with rst=0 -> count=0, out_valid=2'b00, stallreq_for_fifo=0.
- Push num=2, pc=0xBFC00000, insts 0x11111111/0x22222222, pop 0 -> next cycle:
  - count=2, out_valid=11
  - out_pc0=0xBFC00000, out_pc1=0xBFC00004
  - out_inst0=0x11111111
- Push num=2 for 4 cycles, no pop -> count 2,4,6,8; stallreq_for_fifo=1 only at count=8. A 5th push leaves count=8 and contents unchanged.
- Push num=1 and pop_num=2 every cycle for 20 cycles, PCs incrementing by 4 -> pointers wrap. Issued PCs appear strictly sequential; count never exceeds 1.
- count=5, assert flush with push_valid=1 and pop_num=2 -> next cycle count=0, out_valid=00, rd_ptr=wr_ptr=0.
- count=4, stall=1, pop_num=2 -> count stays 4 and out_pc0 is unchanged. With stall=0 next cycle, count=2.
